// File: rtl/undolog_copy_engine.sv
// Undo-log copy engine: reads the old contents of a source region in AXI4
// INCR bursts, buffers each burst and writes it to the undo-log region.
module undolog_copy_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_src_addr,
  input  logic [ADDR_W-1:0]   cmd_log_addr,
  input  logic [LEN_W-1:0]    cmd_len,

  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_W-1:0]    beats_done,

  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,

  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,

  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,

  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,

  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int ALIGN  = $clog2(MAX_BURST * BYTES);
  localparam int PTR_W  = $clog2(MAX_BURST);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] log_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  beats_q;
  logic [7:0]        blen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              abort_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic [DATA_W-1:0] mem [MAX_BURST];

  logic              misaligned;
  logic              start_ok;
  logic              r_hs;
  logic              r_bad;
  logic              b_bad;
  logic              abort_b;
  logic              more;
  logic              at_last;
  logic [LEN_W-1:0]  chunk;
  logic [LEN_W-1:0]  rem_next;
  logic [ADDR_W-1:0] step;

  // Burst length field for the next chunk; caller guarantees n != 0.
  function automatic logic [7:0] blen_of(input logic [LEN_W-1:0] n);
    if (n > LEN_W'(MAX_BURST - 1))
      return 8'(MAX_BURST - 1);
    return 8'(n - LEN_W'(1));
  endfunction

  assign misaligned = (|cmd_src_addr[ALIGN-1:0]) ||
                      (|cmd_log_addr[ALIGN-1:0]);
  assign start_ok   = (cmd_len != '0) && !misaligned;

  assign chunk    = LEN_W'(blen_q) + LEN_W'(1);
  assign rem_next = rem_q - chunk;
  assign step     = ADDR_W'(chunk) << BSHIFT;
  assign at_last  = (cnt_q == CNT_W'(blen_q));

  assign r_hs  = (state == RD_DATA) && M_AXI_RVALID;
  assign r_bad = (M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != at_last);
  assign b_bad = (M_AXI_BRESP != 2'b00);

  assign abort_b = abort_q || b_bad;
  assign more    = (rem_next != '0) && !abort_b;

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign beats_done = beats_q;

  assign M_AXI_ARADDR = src_q;
  assign M_AXI_ARLEN  = blen_q;
  assign M_AXI_AWADDR = log_q;
  assign M_AXI_AWLEN  = blen_q;
  assign M_AXI_WDATA  = mem[cnt_q[PTR_W-1:0]];
  assign M_AXI_WSTRB  = '1;

  always_ff @(posedge ACLK) begin
    if (ARESET)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    cmd_ready     = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_n = start_ok ? RD_ADDR : FINISH;
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY)
          state_n = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID && M_AXI_RLAST)
          state_n = WR_ADDR;
      end
      WR_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY)
          state_n = WR_DATA;
      end
      WR_DATA: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = at_last;
        if (M_AXI_WREADY && at_last)
          state_n = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID)
          state_n = more ? RD_ADDR : FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Burst buffer: no reset needed, every entry is written before it is read.
  always_ff @(posedge ACLK) begin
    if (r_hs)
      mem[cnt_q[PTR_W-1:0]] <= M_AXI_RDATA;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      src_q   <= '0;
      log_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_q   <= cmd_src_addr;
            log_q   <= cmd_log_addr;
            rem_q   <= cmd_len;
            beats_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            abort_q <= misaligned;
            cnt_q   <= '0;
            if (start_ok)
              blen_q <= blen_of(cmd_len);
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY)
            cnt_q <= '0;
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (r_bad)
              abort_q <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (M_AXI_AWREADY)
            cnt_q <= '0;
        end
        WR_DATA: begin
          if (M_AXI_WREADY)
            cnt_q <= cnt_q + CNT_W'(1);
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            abort_q <= abort_b;
            if (!abort_b)
              beats_q <= beats_q + chunk;
            src_q <= src_q + step;
            log_q <= log_q + step;
            rem_q <= rem_next;
            if (more)
              blen_q <= blen_of(rem_next);
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          error_q <= abort_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_undolog_copy_engine.sv
// Directed bench for undolog_copy_engine with an in-loop AXI4 slave model
// that checks handshake stability, ordering and burst shape.
module tb_undolog_copy_engine;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_log = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, error;
  logic [15:0] beats_done;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wmem [logic [31:0]];

  always #5 clk = ~clk;

  undolog_copy_engine dut (
    .ACLK(clk), .ARESET(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src), .cmd_log_addr(cmd_log), .cmd_len(cmd_len),
    .busy(busy), .done(done), .error(error), .beats_done(beats_done),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] log;
    int          len;
    bit          stall;
    int          err_burst;
    int          exp_error;
    int          exp_beats;
    int          exp_ar;
    int          exp_w;
    int          exp_lat;
  } vec_t;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_1E0F;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = 2'b00;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  function automatic bit coin(input bit stall);
    return !stall || ($urandom_range(0, 1) == 1);
  endfunction

  function automatic int burst_len(input int len, input int k);
    int rem;
    rem = len - 16 * k;
    return (rem > 16) ? 15 : rem - 1;
  endfunction

  task automatic run_cmd(input vec_t v, input bit stop_w, input string tag);
    bit          accd = 0, done_seen = 0;
    bit          rd_act = 0, aw_got = 0, b_pend = 0;
    int          acc = -1, first_ar = -1, done_at = -1;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int          rd_beat = 0, wr_beat = 0, rd_len = 0, wr_len = 0;
    int          shape = 0, proto = 0, busy_bad = 0, mism = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, a;
    bit          p_ar = 0, p_aw = 0, p_w = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [7:0]  p_arlen = '0, p_awlen = '0;
    logic        p_wlast = 1'b0;
    wmem.delete();
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      @(negedge clk);
      if (p_ar && !(arvalid && araddr == p_araddr && arlen == p_arlen))
        proto++;
      if (p_aw && !(awvalid && awaddr == p_awaddr && awlen == p_awlen))
        proto++;
      if (p_w && !(wvalid && wdata == p_wdata && wlast == p_wlast))
        proto++;
      if (done) begin
        done_seen = 1;
        done_at = cyc;
      end
      if (acc >= 0 && cyc == acc + 1 && !busy)
        busy_bad++;
      if (stop_w && wvalid) begin
        areset = 1'b1;
        cmd_valid = 1'b0;
        slave_idle();
        return;
      end
      if (accd) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_src = v.src;
        cmd_log = v.log;
        cmd_len = 16'(v.len);
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          accd = 1;
          acc = cyc;
        end
      end
      if (arvalid && (rd_act || aw_got || b_pend)) proto++;
      if (awvalid && (rd_act || b_pend)) proto++;
      if (wvalid && !aw_got) proto++;
      // B before W, R before AR: a response never shares its request's cycle
      bresp = 2'b00;
      bvalid = b_pend && coin(v.stall);
      if (bvalid && bready) b_pend = 0;
      wready = coin(v.stall);
      if (wvalid && wready && aw_got) begin
        if (wlast != (wr_beat == wr_len)) proto++;
        wmem[wr_addr + 32'(4 * wr_beat)] = wdata;
        w_cnt++;
        if (wr_beat == wr_len) begin
          aw_got = 0;
          b_pend = 1;
        end else begin
          wr_beat++;
        end
      end
      awready = coin(v.stall);
      if (awvalid && awready) begin
        if (awaddr != v.log + 32'(64 * aw_cnt) ||
            awlen != 8'(burst_len(v.len, aw_cnt))) shape++;
        wr_addr = awaddr;
        wr_len = int'(awlen);
        wr_beat = 0;
        aw_got = 1;
        aw_cnt++;
      end
      rvalid = rd_act && coin(v.stall);
      rdata = src_word(rd_addr + 32'(4 * rd_beat));
      rlast = (rd_beat == rd_len);
      rresp = (ar_cnt == v.err_burst && rd_beat == 2) ? 2'b10 : 2'b00;
      if (rvalid && rready) begin
        if (rlast) rd_act = 0;
        else rd_beat++;
      end
      arready = coin(v.stall);
      if (arvalid && first_ar < 0) first_ar = cyc;
      if (arvalid && arready) begin
        if (araddr != v.src + 32'(64 * ar_cnt) ||
            arlen != 8'(burst_len(v.len, ar_cnt))) shape++;
        rd_addr = araddr;
        rd_len = int'(arlen);
        rd_beat = 0;
        rd_act = 1;
        ar_cnt++;
      end
      p_ar = arvalid && !arready;
      p_araddr = araddr;
      p_arlen = arlen;
      p_aw = awvalid && !awready;
      p_awaddr = awaddr;
      p_awlen = awlen;
      p_w = wvalid && !wready;
      p_wdata = wdata;
      p_wlast = wlast;
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    slave_idle();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_error"}, error, v.exp_error);
    chk({tag, "_beats_done"}, beats_done, v.exp_beats);
    chk({tag, "_ar_count"}, ar_cnt, v.exp_ar);
    chk({tag, "_aw_count"}, aw_cnt, v.exp_ar);
    chk({tag, "_w_beats"}, w_cnt, v.exp_w);
    chk({tag, "_burst_shape"}, shape, 0);
    chk({tag, "_protocol"}, proto, 0);
    chk({tag, "_busy_on_accept"}, busy_bad, 0);
    if (v.exp_lat > 0)
      chk({tag, "_done_latency"}, done_at - acc, v.exp_lat);
    if (v.exp_ar > 0)
      chk({tag, "_ar_latency"}, first_ar - acc, 1);
    for (int i = 0; i < v.exp_w; i++) begin
      a = v.log + 32'(4 * i);
      if (!wmem.exists(a) || wmem[a] != src_word(v.src + 32'(4 * i)))
        mism++;
    end
    chk({tag, "_log_data"}, mism, 0);
  endtask

  vec_t vecs [9];
  vec_t rv;

  initial begin
    //          src            log            len stl eb er beats ar  w  lat
    vecs[0] = '{32'h0000_1000, 32'h0000_8000, 16, 0, 0, 0, 16, 1, 16, 0};
    vecs[1] = '{32'h0000_1000, 32'h0000_8000, 40, 0, 0, 0, 40, 3, 40, 0};
    vecs[2] = '{32'h0000_1000, 32'h0000_8000, 33, 1, 0, 0, 33, 3, 33, 0};
    vecs[3] = '{32'h0000_1000, 32'h0000_8000, 48, 0, 2, 1, 16, 2, 32, 0};
    vecs[4] = '{32'h0000_1000, 32'h0000_8000,  0, 0, 0, 0,  0, 0,  0, 2};
    vecs[5] = '{32'h0000_1004, 32'h0000_8000,  4, 0, 0, 1,  0, 0,  0, 2};
    vecs[6] = '{32'h0000_1000, 32'h0000_8020,  8, 0, 0, 1,  0, 0,  0, 2};
    vecs[7] = '{32'h0000_2040, 32'h0000_9FC0,  1, 1, 0, 0,  1, 1,  1, 0};
    vecs[8] = '{32'hFFFF_FFC0, 32'h0000_4000, 32, 0, 0, 0, 32, 2, 32, 0};

    slave_idle();
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_status", {busy, done, error}, 0);
    chk("rst_beats_done", beats_done, 0);
    chk("rst_valid_ready",
        {arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
    chk("rst_addr_len", {araddr, arlen, awaddr, awlen}, 0);
    chk("rst_wstrb", wstrb, 4'hF);

    for (int i = 0; i < 9; i++)
      run_cmd(vecs[i], 1'b0, $sformatf("v%0d", i));

    // reset while the write burst is in flight, then a clean command
    rv = '{32'h0000_3000, 32'h0000_A000, 16, 0, 0, 0, 16, 1, 16, 0};
    run_cmd(rv, 1'b1, "rst_mid");
    @(negedge clk);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_valids", {arvalid, awvalid, rready, bready}, 0);
    areset = 1'b0;
    rv = '{32'h0000_3000, 32'h0000_A000, 4, 0, 0, 0, 4, 1, 4, 0};
    run_cmd(rv, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
